// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the exec_stage sequencer
//
// Contents:
//    W, RW      default datapath width and register index width
//    alu_op_t   ALU operation encoding (ADD, SUB, AND, MVN)
//    shift_t    B-operand shift encoding (NONE, LSL1, LSR1, ASR1)
//    state_t    sequencer states (IDLE, RD_A, RD_B, EXEC, WB)
package exec_pkg;

   localparam int W  = 16;
   localparam int RW = 3;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      MVN = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      LSL1 = 2'b01,
      LSR1 = 2'b10,
      ASR1 = 2'b11
   } shift_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational B shifter, ALU and status flag generation
//
// Optional feature macro: STATUS_OVF_EN (adds the v_o overflow output).
// Ports:
//    a_i       A operand register value
//    b_i       B operand register value (shifted here before use)
//    asel_i    1 forces the A operand to zero
//    op_i      ALU operation
//    shift_i   B shift selection
//    result_o  result modulo 2^W
//    z_o       result is zero
//    n_o       result sign bit
//    v_o       signed overflow for ADD/SUB, 0 for AND/MVN (STATUS_OVF_EN only)
module exec_alu #(
   parameter int W = exec_pkg::W
) (
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic             asel_i,
   input  exec_pkg::alu_op_t op_i,
   input  exec_pkg::shift_t  shift_i,
   output logic [W-1:0]     result_o,
   output logic             z_o,
   output logic             n_o
`ifdef STATUS_OVF_EN
   ,
   output logic             v_o
`endif
);

   import exec_pkg::*;

   logic [W-1:0] ain;
   logic [W-1:0] bsh;

   always_comb begin
      bsh = b_i;
      unique case (shift_i)
         NONE:    bsh = b_i;
         LSL1:    bsh = {b_i[W-2:0], 1'b0};
         LSR1:    bsh = {1'b0, b_i[W-1:1]};
         ASR1:    bsh = {b_i[W-1], b_i[W-1:1]};
         default: bsh = b_i;
      endcase
   end

   assign ain = asel_i ? '0 : a_i;

   always_comb begin
      result_o = '0;
      unique case (op_i)
         ADD:     result_o = ain + bsh;
         SUB:     result_o = ain - bsh;
         AND:     result_o = ain & bsh;
         MVN:     result_o = ~bsh;
         default: result_o = '0;
      endcase
   end

   assign z_o = (result_o == '0);
   assign n_o = result_o[W-1];

`ifdef STATUS_OVF_EN
   // Overflow: operands that (after SUB's implicit negation) share a sign
   // produced a result of the opposite sign.
   always_comb begin
      v_o = 1'b0;
      unique case (op_i)
         ADD:     v_o = (ain[W-1] == bsh[W-1]) && (result_o[W-1] != ain[W-1]);
         SUB:     v_o = (ain[W-1] != bsh[W-1]) && (result_o[W-1] != ain[W-1]);
         default: v_o = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - multi-cycle read/execute/writeback sequencer for an 8x16 register file
//
// Optional feature macro: STATUS_OVF_EN (V flag register; otherwise status_v is 0).
// Ports:
//    clk, reset_n          rising-edge clock, synchronous active-low reset
//    start                 command request, accepted only in IDLE
//    op, shift, asel       ALU operation, B shift, A-operand zero select
//    rn, rm, rd            source A, source B, destination register indices
//    rf_data_out           register file combinational read data
//    rf_readnum            register file read index
//    rf_writenum, rf_write register file write index and enable
//    rf_data_in            register file write data (the C register)
//    busy, done            not-IDLE indicator, one-cycle writeback pulse
//    c_out                 C register
//    status_z/n/v          zero, negative, signed-overflow flags
module exec_stage #(
   parameter int W  = exec_pkg::W,
   parameter int RW = exec_pkg::RW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [1:0]    shift,
   input  logic          asel,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [RW-1:0] rd,
   input  logic [W-1:0]  rf_data_out,
   output logic [RW-1:0] rf_readnum,
   output logic [RW-1:0] rf_writenum,
   output logic          rf_write,
   output logic [W-1:0]  rf_data_in,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  c_out,
   output logic          status_z,
   output logic          status_n,
   output logic          status_v
);

   import exec_pkg::*;

   state_t        state_q, state_d;
   alu_op_t       op_q;
   shift_t        shift_q;
   logic          asel_q;
   logic [RW-1:0] rn_q, rm_q, rd_q;
   logic [W-1:0]  a_q, b_q, c_q;
   logic          z_q, n_q;

   logic [W-1:0]  alu_result;
   logic          alu_z, alu_n;

`ifdef STATUS_OVF_EN
   logic          v_q;
   logic          alu_v;
`endif

   exec_alu #(.W(W)) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .asel_i   (asel_q),
      .op_i     (op_q),
      .shift_i  (shift_q),
      .result_o (alu_result),
      .z_o      (alu_z),
      .n_o      (alu_n)
`ifdef STATUS_OVF_EN
      ,
      .v_o      (alu_v)
`endif
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RD_A;
         RD_A:    state_d = RD_B;
         RD_B:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= ADD;
         shift_q <= NONE;
         asel_q  <= 1'b0;
         rn_q    <= '0;
         rm_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
`ifdef STATUS_OVF_EN
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  op_q    <= alu_op_t'(op);
                  shift_q <= shift_t'(shift);
                  asel_q  <= asel;
                  rn_q    <= rn;
                  rm_q    <= rm;
                  rd_q    <= rd;
               end
            end
            RD_A: a_q <= rf_data_out;
            RD_B: b_q <= rf_data_out;
            EXEC: begin
               c_q <= alu_result;
               z_q <= alu_z;
               n_q <= alu_n;
`ifdef STATUS_OVF_EN
               v_q <= alu_v;
`endif
            end
            default: ;
         endcase
      end
   end

   // Only RD_B reads the B source; every other state presents rn_q.
   assign rf_readnum  = (state_q == RD_B) ? rm_q : rn_q;
   assign rf_writenum = rd_q;
   assign rf_write    = (state_q == WB);
   assign rf_data_in  = c_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == WB);
   assign c_out       = c_q;
   assign status_z    = z_q;
   assign status_n    = n_q;
`ifdef STATUS_OVF_EN
   assign status_v    = v_q;
`else
   assign status_v    = 1'b0;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - self-checking bench for exec_stage with a behavioural register file
module tb_exec_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op, shift;
   logic        asel;
   logic [2:0]  rn, rm, rd;
   logic [15:0] rf_data_out;
   logic [2:0]  rf_readnum, rf_writenum;
   logic        rf_write;
   logic [15:0] rf_data_in;
   logic        busy, done;
   logic [15:0] c_out;
   logic        status_z, status_n, status_v;

   logic [15:0] rf [8];
   logic [15:0] exp_rf [8];

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  shift;
      logic        asel;
      logic [2:0]  rn, rm, rd;
      logic        poke;
      logic [15:0] res;
      logic        z, n, v;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   exec_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .shift       (shift),
      .asel        (asel),
      .rn          (rn),
      .rm          (rm),
      .rd          (rd),
      .rf_data_out (rf_data_out),
      .rf_readnum  (rf_readnum),
      .rf_writenum (rf_writenum),
      .rf_write    (rf_write),
      .rf_data_in  (rf_data_in),
      .busy        (busy),
      .done        (done),
      .c_out       (c_out),
      .status_z    (status_z),
      .status_n    (status_n),
      .status_v    (status_v)
   );

   // Register file environment: combinational read, clocked write.
   assign rf_data_out = rf[rf_readnum];
   always @(posedge clk) begin
      if (rf_write) rf[rf_writenum] <= rf_data_in;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic ovf_expect(input logic v);
`ifdef STATUS_OVF_EN
      return v;
`else
      return 1'b0 & v;
`endif
   endfunction

   task automatic check_rf_all(input string name);
      int bad = 0;
      for (int k = 0; k < 8; k++) if (rf[k] !== exp_rf[k]) bad++;
      check(name, bad, 0);
   endtask

   // Issue one command, observe 8 cycles after the accepting edge, then
   // check timing, the written register and the status flags.
   task automatic run_cmd(input string name, input logic [1:0] c_op, input logic [1:0] c_sh,
                          input logic c_asel, input logic [2:0] c_rn, input logic [2:0] c_rm,
                          input logic [2:0] c_rd, input logic poke, input logic [15:0] e_res,
                          input logic e_z, input logic e_n, input logic e_v);
      logic [7:0] done_pat, busy_pat;
      @(negedge clk);
      start = 1'b1; op = c_op; shift = c_sh; asel = c_asel; rn = c_rn; rm = c_rm; rd = c_rd;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         done_pat[i] = done;
         busy_pat[i] = busy;
         start = 1'b0;
         // Requests while busy (RD_B) and during WB must be dropped.
         if (poke && (i == 1 || i == 3)) begin
            start = 1'b1; op = 2'b11; rn = 3'd1; rm = 3'd1; rd = 3'd0;
         end
      end
      exp_rf[c_rd] = e_res;
      check({name, "_done"}, done_pat, 8'b0000_1000);
      check({name, "_busy"}, busy_pat, 8'b0000_1111);
      check({name, "_rd"}, rf[c_rd], e_res);
      check({name, "_c"}, c_out, e_res);
      check({name, "_znv"}, {status_z, status_n, status_v}, {e_z, e_n, ovf_expect(e_v)});
      check_rf_all({name, "_rf"});
   endtask

   function automatic int sgn(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   initial begin
      int a, b, bs, r, s;
      logic [1:0] r_op, r_sh;
      logic r_asel, r_v;
      logic [2:0] r_rn, r_rm, r_rd;
      logic [15:0] pick [6];

      tbl[0] = '{2'd0, 2'd1, 1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h000E, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{2'd1, 2'd0, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{2'd2, 2'd0, 1'b0, 3'd1, 3'd4, 3'd5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{2'd3, 2'd0, 1'b1, 3'd0, 3'd5, 3'd6, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'd0, 2'd3, 1'b1, 3'd0, 3'd7, 3'd7, 1'b0, 16'hC000, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{2'd1, 2'd0, 1'b0, 3'd1, 3'd2, 3'd2, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{2'd0, 2'd2, 1'b1, 3'd0, 3'd6, 3'd4, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{2'd0, 2'd2, 1'b0, 3'd4, 3'd2, 3'd3, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1};

      exp_rf = '{16'h0000, 16'h0006, 16'h0004, 16'h1234, 16'h0009, 16'h5555, 16'h0000, 16'h8000};
      for (int i = 0; i < 8; i++) rf[i] <= exp_rf[i];

      reset_n = 1'b0; start = 1'b0; op = '0; shift = '0; asel = 1'b0;
      rn = '0; rm = '0; rd = '0;
      repeat (3) @(negedge clk);
      check("reset_busy_done_wr", {busy, done, rf_write}, 3'b000);
      check("reset_c", c_out, 16'h0000);
      check("reset_znv", {status_z, status_n, status_v}, 3'b000);
      reset_n = 1'b1;

      for (int t = 0; t < 8; t++)
         run_cmd($sformatf("vec%0d", t), tbl[t].op, tbl[t].shift, tbl[t].asel, tbl[t].rn,
                 tbl[t].rm, tbl[t].rd, tbl[t].poke, tbl[t].res, tbl[t].z, tbl[t].n, tbl[t].v);

      // Reset in EXEC: ADD R1(6) + LSL1(R2=2) would write 0x000A to R3.
      @(negedge clk);
      start = 1'b1; op = 2'd0; shift = 2'd1; asel = 1'b0; rn = 3'd1; rm = 3'd2; rd = 3'd3;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_busy_done_wr", {busy, done, rf_write}, 3'b000);
      check("midrst_c", c_out, 16'h0000);
      check("midrst_znv", {status_z, status_n, status_v}, 3'b000);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_busy_after", busy, 1'b0);
      check_rf_all("midrst_rf");

      // Random commands against an arithmetic reference model.
      pick = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h4000};
      for (int i = 0; i < 8; i++) begin
         exp_rf[i] = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : 16'($urandom);
         rf[i] <= exp_rf[i];
      end
      @(negedge clk);
      for (int t = 0; t < 40; t++) begin
         r_op = 2'($urandom); r_sh = 2'($urandom);
         r_asel = ($urandom_range(0, 3) == 0);
         r_rn = 3'($urandom); r_rm = 3'($urandom); r_rd = 3'($urandom);
         a = r_asel ? 0 : int'(exp_rf[r_rn]);
         b = int'(exp_rf[r_rm]);
         case (r_sh)
            2'd0: bs = b;
            2'd1: bs = (b * 2) % 65536;
            2'd2: bs = b / 2;
            default: bs = b / 2 + ((b >= 32768) ? 32768 : 0);
         endcase
         r_v = 1'b0;
         case (r_op)
            2'd0: begin r = (a + bs) % 65536; s = sgn(a) + sgn(bs); r_v = (s > 32767) || (s < -32768); end
            2'd1: begin r = (a - bs + 65536) % 65536; s = sgn(a) - sgn(bs); r_v = (s > 32767) || (s < -32768); end
            2'd2: r = a & bs;
            default: r = 65535 - bs;
         endcase
         run_cmd($sformatf("rnd%0d", t), r_op, r_sh, r_asel, r_rn, r_rm, r_rd, 1'b0,
                 16'(r), (r == 0), (r >= 32768), r_v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
